uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLOCK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate; BAUD_TICKS = CLOCK_FREQ / BAUD_RATE (integer divide), BAUD_TICKS SHALL be >= 8.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high; 1 start, 8 data LSB first, 1 stop, no parity.
REQ-006 data_out  output  8  last accepted byte; stable while data_valid high.
REQ-007 data_valid  output  1  level, high while data_out holds an unconsumed byte.
REQ-008 data_ack  input  1  consumer acknowledge; honoured only while data_valid high.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: byte completed while previous unconsumed.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 rx SHALL pass a 2-FF synchronizer; decisions use synchronized value rx_s and its one-cycle-delayed copy rx_d; input-to-decision latency 2 cycles.
REQ-013 FSM states IDLE, START, DATA, STOP; 16-bit down-counter cnt, 3-bit bit_idx, 8-bit shift register.
REQ-014 IDLE: on falling edge (rx_d=1, rx_s=0) -> START, cnt <= BAUD_TICKS/2 - 1; a line held low without a new falling edge SHALL NOT start a frame.
REQ-015 START: cnt decrements; at cnt=0 sample; sample=0 -> DATA, bit_idx <= 0, cnt <= BAUD_TICKS-1; sample=1 -> IDLE (false start, no outputs).
REQ-016 DATA: at cnt=0 shift[bit_idx] <= sample, cnt <= BAUD_TICKS-1; bit_idx=7 -> STOP, else bit_idx+1.
REQ-017 STOP: at cnt=0 -> IDLE; sample=1 -> deliver byte; sample=0 -> frame_err pulse, byte discarded.
REQ-018 Deliver: if data_valid=0, or data_ack=1 same cycle, data_out <= byte and data_valid <= 1 next cycle; otherwise overrun pulse, data_out unchanged, new byte dropped.
REQ-019 data_ack with data_valid=1 and no simultaneous delivery SHALL clear data_valid next cycle; data_ack with data_valid=0 ignored.
REQ-020 Receiver re-arms at mid-stop-bit, so back-to-back frames from a BAUD_TICKS-exact transmitter SHALL be received with no loss.

Reset
REQ-021 rst=1 at any clock edge, including mid-frame: state IDLE, cnt 0, bit_idx 0, shift 0, data_out 0x00, data_valid 0, frame_err 0, overrun 0, busy 0, synchronizer FFs 1; partial frame discarded.
REQ-022 After rst deasserts with rx low, no frame starts until a fresh falling edge.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN defined: sample = majority of rx_s at cnt=2,1,0 (three consecutive cycles ending on decision cycle).
REQ-024 Macro undefined: sample = rx_s at cnt=0 only; no majority logic synthesized.

Structure
REQ-025 Package uart_pkg SHALL hold state_t enum {IDLE, START, DATA, STOP} (2-bit) and a baud_ticks(clock_freq, baud_rate) function, shared with the transmitter.
REQ-026 One sub-module uart_rx_sync: 2-FF synchronizer plus falling-edge detect, outputs rx_s and fall.

Verification (bench: CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, BAUD_TICKS=10)
REQ-027 Serialize 0xA5 at 10 cycles/bit -> data_valid rises ~ mid-stop, data_out=0xA5, frame_err=0, overrun=0; data_ack -> data_valid 0 next cycle.
REQ-028 rx low for 3 cycles then high -> returns to IDLE, no data_valid, no frame_err.
REQ-029 Frame 0x3C with stop bit 0 -> frame_err one-cycle pulse, data_valid stays 0, next valid frame 0x55 received correctly.
REQ-030 Frames 0x11 then 0x22 back-to-back, no data_ack -> data_out=0x11, overrun pulse at second stop; ack on same cycle as second delivery -> data_out=0x22, no overrun.
REQ-031 rst asserted mid-DATA of 0xFF, rx held low -> all outputs reset values, no frame until next falling edge; following 0x81 received correctly.
REQ-032 With UART_RX_MAJORITY_EN, 1-cycle inverted glitch at mid-bit 3 of 0x00 -> data_out=0x00; without macro same stimulus -> data_out=0x08.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and baud divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Clock cycles per serial bit; integer divide so both ends agree on the same value.
  function automatic int unsigned baud_ticks(input int unsigned clock_freq,
                                             input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus falling-edge detect on the synchronized value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic       rx_meta;
  logic       rx_d;
  logic [1:0] warm;
  logic       armed;

  // The flops reset to the idle level; edges are only trusted once a genuine high has been
  // seen, so a line already low when reset releases cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
      warm    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
      warm    <= {warm[0], 1'b1};
      armed   <= armed | (warm[1] & rx_s);
    end
  end

  assign fall = armed & rx_d & ~rx_s;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with single-entry output holding register.
// Define UART_RX_MAJORITY_EN to take each bit as a 3-sample majority vote.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int          BAUD_TICKS = int'(baud_ticks(CLOCK_FREQ, BAUD_RATE));
  localparam logic [15:0] CNT_FULL   = 16'(BAUD_TICKS - 1);
  localparam logic [15:0] CNT_HALF   = 16'(BAUD_TICKS / 2 - 1);

  logic rx_s;
  logic fall;
  logic sample;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rx_s (rx_s),
    .fall (fall)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_s};
  end

  assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign sample = rx_s;
`endif

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic [7:0]  shift, shift_next;
  logic        deliver;
  logic        frame_bad;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shift   <= shift_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    deliver      = 1'b0;
    frame_bad    = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_next = START;
          cnt_next   = CNT_HALF;
        end
      end
      START: begin
        if (cnt == 16'd0) begin
          if (!sample) begin
            state_next   = DATA;
            bit_idx_next = 3'd0;
            cnt_next     = CNT_FULL;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == 16'd0) begin
          shift_next[bit_idx] = sample;
          cnt_next            = CNT_FULL;
          if (bit_idx == 3'd7) state_next   = STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      STOP: begin
        // Re-arm at mid-stop so the next start edge is never missed.
        if (cnt == 16'd0) begin
          state_next = IDLE;
          deliver    = sample;
          frame_bad  = ~sample;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      overrun   <= deliver & data_valid & ~data_ack;
      if (deliver && (!data_valid || data_ack)) begin
        data_out   <= shift;
        data_valid <= 1'b1;
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
